// File: rtl/fp_pkg.sv
// Shared FP helpers: width derivation, divider FSM states, IEEE field extraction.
// Helpers take operands zero-extended to 64 bits plus the format width w.
package fp_pkg;

    typedef enum logic [2:0] {IDLE, ALIGN, DIVIDE, ROUND, DONE} fsm_state_t;

    function automatic int fw_of(input int w);
        return (w == 64) ? 52 : 23;
    endfunction

    function automatic int ew_of(input int w);
        return (w == 64) ? 11 : 8;
    endfunction

    function automatic int bias_of(input int w);
        return (1 << (ew_of(w) - 1)) - 1;
    endfunction

    function automatic logic f_sign(input logic [63:0] x, input int w);
        return ((x >> (w - 1)) & 64'd1) != 64'd0;
    endfunction

    function automatic logic [10:0] f_exp(input logic [63:0] x, input int w);
        return 11'((x >> fw_of(w)) & ((64'd1 << ew_of(w)) - 64'd1));
    endfunction

    function automatic logic [51:0] f_frac(input logic [63:0] x, input int w);
        return 52'(x & ((64'd1 << fw_of(w)) - 64'd1));
    endfunction

    function automatic logic is_zero(input logic [63:0] x, input int w);
        return (f_exp(x, w) == 11'd0) && (f_frac(x, w) == 52'd0);
    endfunction

    function automatic logic is_inf(input logic [63:0] x, input int w);
        return (f_exp(x, w) == 11'((1 << ew_of(w)) - 1)) && (f_frac(x, w) == 52'd0);
    endfunction

endpackage

// File: rtl/fp_div_step.sv
// One restoring-division iteration: conditional subtract, emit quotient bit, shift.
// Purely combinational; no flow control.
module fp_div_step #(
    parameter int RW = 25
) (
    input  logic [RW-1:0] rem,
    input  logic [RW-1:0] mb,
    output logic [RW-1:0] next_rem,
    output logic          qbit
);

    always_comb begin
        qbit     = (rem >= mb);
        next_rem = qbit ? RW'({rem - mb, 1'b0}) : RW'({rem, 1'b0});
    end

endmodule

// File: rtl/fp_div.sv
// Iterative IEEE-754 divider y = a/b; fixed latency FW+5 cycles start->valid, specials included.
// start is only sampled while idle; busy covers the whole operation including the valid cycle.
module fp_div
    import fp_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         valid,
    output logic [W-1:0] y
);

    localparam int FW   = fw_of(W);
    localparam int EW   = ew_of(W);
    localparam int BIAS = bias_of(W);
    localparam int XW   = EW + 1;
    localparam int RW   = FW + 2;
    localparam int CW   = $clog2(FW + 2);

    fsm_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          sign_q, sign_d;
    logic [XW-1:0] exp_q, exp_d;
    logic [RW-1:0] rem_q, rem_d;
    logic [FW:0]   mb_q, mb_d;
    logic [RW-1:0] q_q, q_d;
    logic          spec_q, spec_d;
    logic          spec_inf_q, spec_inf_d;
    logic          busy_q, busy_d;
    logic          valid_q, valid_d;
    logic [W-1:0]  y_q, y_d;

    logic [63:0]   a_x, b_x;
    logic [RW-1:0] step_rem, mant_r;
    logic          step_qbit;

    assign a_x = 64'(a);
    assign b_x = 64'(b);

    fp_div_step #(.RW(RW)) u_step (
        .rem      (rem_q),
        .mb       ({1'b0, mb_q}),
        .next_rem (step_rem),
        .qbit     (step_qbit)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sign_d     = sign_q;
        exp_d      = exp_q;
        rem_d      = rem_q;
        mb_d       = mb_q;
        q_d        = q_q;
        spec_d     = spec_q;
        spec_inf_d = spec_inf_q;
        busy_d     = busy_q;
        valid_d    = 1'b0;
        y_d        = y_q;
        // q holds {int, fraction, guard}; half-up round on the guard bit
        mant_r     = {1'b0, q_q[RW-1:1]} + RW'(q_q[0]);
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = ALIGN;
                    busy_d     = 1'b1;
                    sign_d     = f_sign(a_x, W) ^ f_sign(b_x, W);
                    exp_d      = XW'(f_exp(a_x, W)) - XW'(f_exp(b_x, W)) + XW'(BIAS);
                    rem_d      = {1'b0, 1'b1, FW'(f_frac(a_x, W))};
                    mb_d       = {1'b1, FW'(f_frac(b_x, W))};
                    q_d        = '0;
                    cnt_d      = '0;
                    spec_d     = is_zero(a_x, W) || is_inf(b_x, W) ||
                                 is_inf(a_x, W) || is_zero(b_x, W);
                    spec_inf_d = !is_zero(a_x, W) && !is_inf(b_x, W);
                end
            end
            ALIGN: begin
                // pre-shift so the quotient always lands in [1,2)
                if (rem_q < {1'b0, mb_q}) begin
                    rem_d = {rem_q[RW-2:0], 1'b0};
                    exp_d = exp_q - XW'(1);
                end
                state_d = DIVIDE;
            end
            DIVIDE: begin
                rem_d = step_rem;
                q_d   = {q_q[RW-2:0], step_qbit};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(RW - 1)) state_d = ROUND;
            end
            ROUND: begin
                valid_d = 1'b1;
                state_d = DONE;
                if (spec_q) y_d = {sign_q, {EW{spec_inf_q}}, {FW{1'b0}}};
                else        y_d = {sign_q, EW'(exp_q + XW'(mant_r[RW-1])), FW'(mant_r)};
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            sign_q     <= 1'b0;
            exp_q      <= '0;
            rem_q      <= '0;
            mb_q       <= '0;
            q_q        <= '0;
            spec_q     <= 1'b0;
            spec_inf_q <= 1'b0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            y_q        <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sign_q     <= sign_d;
            exp_q      <= exp_d;
            rem_q      <= rem_d;
            mb_q       <= mb_d;
            q_q        <= q_d;
            spec_q     <= spec_d;
            spec_inf_q <= spec_inf_d;
            busy_q     <= busy_d;
            valid_q    <= valid_d;
            y_q        <= y_d;
        end
    end

    assign busy  = busy_q;
    assign valid = valid_q;
    assign y     = y_q;

endmodule

// File: tb/tb_fp_div.sv
// Bench for fp_div at W=32 and W=64: scoreboarded results, latency, handshake and reset abort.
module tb_fp_div;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start32, start64;
    logic [31:0] a32, b32, y32;
    logic [63:0] a64, b64, y64;
    logic        busy32, valid32, busy64, valid64;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [63:0] sb[$];

    always #5 clk = ~clk;

    fp_div #(.W(32)) dut32 (
        .clk(clk), .reset_n(reset_n), .start(start32), .a(a32), .b(b32),
        .busy(busy32), .valid(valid32), .y(y32)
    );

    fp_div #(.W(64)) dut64 (
        .clk(clk), .reset_n(reset_n), .start(start64), .a(a64), .b(b64),
        .busy(busy64), .valid(valid64), .y(y64)
    );

    function automatic logic [63:0] sb_pop();
        if (sb.size() > 0) return sb.pop_front();
        return '1;
    endfunction

    // Drive one start pulse; returns just after the accepting edge (cycle T).
    task automatic issue(input bit sel, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] exp_y);
        @(negedge clk);
        if (sel) begin start64 = 1'b1; a64 = a; b64 = b; end
        else     begin start32 = 1'b1; a32 = a[31:0]; b32 = b[31:0]; end
        sb.push_back(exp_y);
        @(posedge clk);
    endtask

    // Wait (bounded) for valid; lat is cycles after T, -1 on timeout.
    task automatic watch(input bit sel, input int maxc, output int lat,
                         output logic [63:0] yv, output bit busy_ok);
        lat = -1;
        yv = '0;
        busy_ok = 1'b1;
        for (int k = 1; k <= maxc; k++) begin
            @(negedge clk);
            start32 = 1'b0;
            start64 = 1'b0;
            if (!(sel ? busy64 : busy32)) busy_ok = 1'b0;
            if (sel ? valid64 : valid32) begin
                lat = k;
                yv = sel ? y64 : {32'b0, y32};
                break;
            end
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        n_cmp += 6;
        if (busy32 !== 1'b0)  begin n_bad++; $display("FAIL reset_busy32 got=%b exp=0", busy32); end
        if (valid32 !== 1'b0) begin n_bad++; $display("FAIL reset_valid32 got=%b exp=0", valid32); end
        if (y32 !== 32'h0)    begin n_bad++; $display("FAIL reset_y32 got=%h exp=0", y32); end
        if (busy64 !== 1'b0)  begin n_bad++; $display("FAIL reset_busy64 got=%b exp=0", busy64); end
        if (valid64 !== 1'b0) begin n_bad++; $display("FAIL reset_valid64 got=%b exp=0", valid64); end
        if (y64 !== 64'h0)    begin n_bad++; $display("FAIL reset_y64 got=%h exp=0", y64); end
    endtask

    task automatic test_basic;
        int lat;
        logic [63:0] yv, ey;
        bit bok;
        issue(1'b0, 64'h40C00000, 64'h40000000, 64'h40400000);
        watch(1'b0, 40, lat, yv, bok);
        ey = sb_pop();
        n_cmp += 3;
        if (yv !== ey)   begin n_bad++; $display("FAIL basic_y got=%h exp=%h", yv, ey); end
        if (lat !== 28)  begin n_bad++; $display("FAIL basic_latency got=%0d exp=28", lat); end
        if (bok !== 1'b1) begin n_bad++; $display("FAIL basic_busy_window got=%b exp=1", bok); end
        @(negedge clk);
        n_cmp++;
        if (busy32 !== 1'b0) begin n_bad++; $display("FAIL basic_busy_drop got=%b exp=0", busy32); end
    endtask

    task automatic test_vectors;
        logic [31:0] va[10], vb[10], vy[10];
        int lat;
        logic [63:0] yv, ey;
        bit bok;
        va = '{32'h3F800000, 32'h3FC00000, 32'hC0C00000, 32'h40000000, 32'hBF800000,
               32'h00000000, 32'h00000000, 32'h3F800000, 32'h7F800000, 32'h80000000};
        vb = '{32'h40400000, 32'h3FC00000, 32'h40000000, 32'h3F800000, 32'h00000000,
               32'h40A00000, 32'h00000000, 32'h7F800000, 32'h3F800000, 32'h3F800000};
        vy = '{32'h3EAAAAAB, 32'h3F800000, 32'hC0400000, 32'h40000000, 32'hFF800000,
               32'h00000000, 32'h00000000, 32'h00000000, 32'h7F800000, 32'h80000000};
        for (int i = 0; i < 10; i++) begin
            issue(1'b0, 64'(va[i]), 64'(vb[i]), 64'(vy[i]));
            watch(1'b0, 40, lat, yv, bok);
            ey = sb_pop();
            n_cmp += 2;
            if (yv !== ey)  begin n_bad++; $display("FAIL vec%0d_y a=%h b=%h got=%h exp=%h", i, va[i], vb[i], yv, ey); end
            if (lat !== 28) begin n_bad++; $display("FAIL vec%0d_latency got=%0d exp=28", i, lat); end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back;
        int nval, k1, k2;
        bit hold_bad;
        logic [63:0] ey;
        nval = 0; k1 = -1; k2 = -1; hold_bad = 1'b0;
        issue(1'b0, 64'h40C00000, 64'h40000000, 64'h40400000);
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            start32 = 1'b0;
            if (valid32) begin
                nval++;
                if (nval == 1) k1 = k; else k2 = k;
                ey = sb_pop();
                n_cmp++;
                if ({32'b0, y32} !== ey) begin n_bad++; $display("FAIL b2b_y%0d got=%h exp=%h", nval, y32, ey); end
            end
            if (k >= 29 && k <= 56 && y32 !== 32'h40400000) hold_bad = 1'b1;
            if (k == 1 || k == 10 || k == 28) begin
                start32 = 1'b1; a32 = 32'h3FC00000; b32 = 32'h3FC00000;
            end
            if (k == 29) begin
                start32 = 1'b1; a32 = 32'h3F800000; b32 = 32'h40400000;
                sb.push_back(64'h3EAAAAAB);
            end
        end
        n_cmp += 4;
        if (nval !== 2)      begin n_bad++; $display("FAIL b2b_valid_count got=%0d exp=2", nval); end
        if (k1 !== 28)       begin n_bad++; $display("FAIL b2b_first_valid got=%0d exp=28", k1); end
        if (k2 !== 57)       begin n_bad++; $display("FAIL b2b_second_valid got=%0d exp=57", k2); end
        if (hold_bad !== 1'b0) begin n_bad++; $display("FAIL b2b_y_hold got=%b exp=0", hold_bad); end
    endtask

    task automatic test_reset_mid;
        int nval, kv;
        logic [63:0] ey;
        logic [63:0] dropped;
        nval = 0; kv = -1;
        issue(1'b0, 64'h3F800000, 64'h40400000, 64'h3EAAAAAB);
        for (int k = 1; k <= 45; k++) begin
            @(negedge clk);
            start32 = 1'b0;
            if (k == 10) reset_n = 1'b0;
            if (k == 11) begin
                reset_n = 1'b1;
                dropped = sb_pop();
                n_cmp += 3;
                if (busy32 !== 1'b0)  begin n_bad++; $display("FAIL rst_mid_busy got=%b exp=0", busy32); end
                if (valid32 !== 1'b0) begin n_bad++; $display("FAIL rst_mid_valid got=%b exp=0", valid32); end
                if (y32 !== 32'h0)    begin n_bad++; $display("FAIL rst_mid_y got=%h exp=0", y32); end
            end
            if (k == 12) begin
                start32 = 1'b1; a32 = 32'h40C00000; b32 = 32'h40000000;
                sb.push_back(64'h40400000);
            end
            if (valid32) begin
                nval++;
                kv = k;
                ey = sb_pop();
                n_cmp++;
                if ({32'b0, y32} !== ey) begin n_bad++; $display("FAIL rst_mid_result got=%h exp=%h", y32, ey); end
            end
        end
        n_cmp += 2;
        if (nval !== 1) begin n_bad++; $display("FAIL rst_mid_valid_count got=%0d exp=1", nval); end
        if (kv !== 40)  begin n_bad++; $display("FAIL rst_mid_valid_cycle got=%0d exp=40", kv); end
    endtask

    task automatic test_w64;
        logic [63:0] va[2], vb[2], vy[2];
        int lat;
        logic [63:0] yv, ey;
        bit bok;
        va = '{64'h4018000000000000, 64'h3FF0000000000000};
        vb = '{64'h4000000000000000, 64'h4008000000000000};
        vy = '{64'h4008000000000000, 64'h3FD5555555555555};
        for (int i = 0; i < 2; i++) begin
            issue(1'b1, va[i], vb[i], vy[i]);
            watch(1'b1, 70, lat, yv, bok);
            ey = sb_pop();
            n_cmp += 3;
            if (yv !== ey)    begin n_bad++; $display("FAIL w64_%0d_y got=%h exp=%h", i, yv, ey); end
            if (lat !== 57)   begin n_bad++; $display("FAIL w64_%0d_latency got=%0d exp=57", i, lat); end
            if (bok !== 1'b1) begin n_bad++; $display("FAIL w64_%0d_busy_window got=%b exp=1", i, bok); end
            @(negedge clk);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog timeout compared=%0d mismatched=%0d", n_cmp, n_bad);
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0;
        start32 = 1'b0; start64 = 1'b0;
        a32 = '0; b32 = '0; a64 = '0; b64 = '0;
        repeat (3) @(posedge clk);
        test_reset();
        reset_n = 1'b1;
        test_basic();
        test_vectors();
        test_back_to_back();
        test_reset_mid();
        test_w64();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
